calc_result_display: RTL
========================

CALC_RESULT_DISPLAY -- requirements
Module: calc_result_display

Interface
REQ-001 SHALL have parameter: REFRESH_DIV, 1000, clock cycles each digit stays enabled (legal range >= 2).
REQ-002 SHALL have port: clk_i  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: result_i  input  5  calculator result.
REQ-005 SHALL have port: result_valid_i  input  1  level-high while result_i is valid (driven by calculator output_valid_o).
REQ-006 SHALL have port: capture_i  input  1  capture request (driven by the calc strobe).
REQ-007 SHALL have port: signed_i  input  1  1 = result_i is two's complement; 0 = unsigned.
REQ-008 SHALL have port: clear_i  input  1  synchronous blank of the display.
REQ-009 SHALL have port: seg_o  output  7  segments {g,f,e,d,c,b,a}, active-high.
REQ-010 SHALL have port: an_o  output  3  one-hot digit enable, active-high; bit0 = ones, bit1 = tens, bit2 = sign.
REQ-011 SHALL have port: busy_o  output  1  high while a conversion is in progress.
REQ-012 SHALL have port: done_o  output  1  one-cycle pulse when new digits are loaded.

Function
REQ-013 SHALL use a 3-state FSM: IDLE, CONVERT, and LOAD.
REQ-014 SHALL capture in IDLE when capture_i && result_valid_i && !clear_i: store sign = signed_i & result_i[4] and magnitude = sign ? (~result_i + 1) mod 32 : result_i (5 bits; -16 -> 16), then go to CONVERT.
REQ-015 SHALL spend exactly 5 cycles in CONVERT, doing one double-dabble step per cycle: if ones >= 5 add 3 to ones, then shift {tens[1:0], ones[3:0], mag[4:0]} left by 1.
REQ-016 SHALL spend 1 cycle in LOAD: copy sign, tens and ones into the display registers, pulse done_o, and return to IDLE.
REQ-017 SHALL, for a capture at edge N, have new digits and done_o visible after edge N+6; busy_o is high after edges N+1..N+6 inclusive, i.e. in CONVERT and LOAD.
REQ-018 SHALL keep the previously displayed value unchanged until LOAD.
REQ-019 SHALL ignore capture_i while in CONVERT or LOAD, with no queuing.
REQ-020 SHALL compute digit codes as follows: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, '-'=40, blank=00 (hex).
REQ-021 SHALL show '-' on the sign digit when sign=1, else blank.
REQ-022 SHALL blank the tens digit when tens=0 (leading-zero suppression).
REQ-023 SHALL always show the ones digit once a value has been loaded.
REQ-024 SHALL keep a 'shown' flag: cleared by reset/clear, set at LOAD; when shown=0, seg_o=00 for all digits.
REQ-025 SHALL run a refresh counter from 0..REFRESH_DIV-1 that wraps to 0; on wrap the digit index advances 0->1->2->0.
REQ-026 SHALL drive an_o = 1<<index and seg_o combinationally from the current index; the refresh runs in all states.
REQ-027 SHALL, on clear_i, force the FSM to IDLE, clear shown, drop busy_o, and suppress done_o in that cycle; clear_i takes priority over simultaneous capture and LOAD.
REQ-028 SHALL not stop the refresh counter or the digit index on clear_i.
REQ-029 SHALL never produce tens > 3 or ones > 9 for any 5-bit input.

Reset
REQ-030 SHALL, on rst_i assertion (asynchronous, any state including mid-CONVERT), set: FSM=IDLE, shown=0, digit registers=0, refresh counter=0, index=0, busy_o=0, done_o=0.
REQ-031 SHALL, while reset is asserted, drive an_o=001 and seg_o=00.
REQ-032 SHALL, after reset release, begin refresh counting on the first clock edge.

Verification
REQ-033 SHALL cover: signed_i=0, result_i=10111 (23), capture at edge N -> done_o at N+6; digits sign=blank(00), tens=5B, ones=4F.
REQ-034 SHALL cover: signed_i=1, result_i=11101 (-3) -> sign=40, tens=00, ones=4F.
REQ-035 SHALL cover: signed_i=1, result_i=10000 (-16) -> sign=40, tens=06, ones=7D; signed_i=0 with result_i=00000 -> ones=3F, tens=00.
REQ-036 SHALL cover: capture, then a second capture 2 cycles later with a different value -> second ignored, first value displayed, single done_o.
REQ-037 SHALL cover: clear_i at cycle 3 of CONVERT -> busy_o=0 next cycle, no done_o, all seg_o=00; also rst_i mid-CONVERT -> all REQ-030 values immediately.
REQ-038 SHALL cover: REFRESH_DIV=4 -> an_o sequence 001,010,100,001, each held exactly 4 cycles from reset release.

Source files
------------

// File: rtl/calc_result_display.sv
`default_nettype none
// ============================================================================
// Module   : calc_result_display
// Purpose  : Captures a 5-bit calculator result (signed or unsigned), converts
//            its magnitude to two BCD digits with a 5-step serial
//            double-dabble, and drives a 3-digit multiplexed 7-segment
//            display (sign, tens, ones).
// Ports    : clk_i          - system clock, rising edge
//            rst_i          - asynchronous active-high reset
//            result_i       - calculator result (5 bits)
//            result_valid_i - result_i is valid
//            capture_i      - capture request
//            signed_i       - 1: result_i is two's complement
//            clear_i        - synchronous display blank / FSM abort
//            seg_o          - segments {g,f,e,d,c,b,a}, active-high
//            an_o           - one-hot digit enable (bit0 ones, bit1 tens,
//                             bit2 sign)
//            busy_o         - conversion in progress
//            done_o         - one-cycle pulse when new digits are loaded
// Revision : 1.0 - initial release
// ============================================================================
module calc_result_display #(
    parameter int REFRESH_DIV = 1000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] result_i,
    input  logic       result_valid_i,
    input  logic       capture_i,
    input  logic       signed_i,
    input  logic       clear_i,
    output logic [6:0] seg_o,
    output logic [2:0] an_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int               c_CW           = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_CW-1:0]  c_REFRESH_LAST = c_CW'(REFRESH_DIV - 1);
    localparam logic [c_CW-1:0]  c_CNT_ONE      = c_CW'(1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_CONVERT = 2'd1;
    localparam logic [1:0] c_ST_LOAD    = 2'd2;

    localparam logic [6:0] c_SEG_MINUS  = 7'h40;

    // Working registers for the conversion
    logic [1:0]      r_state;
    logic [2:0]      r_step;
    logic            r_sign;
    logic [4:0]      r_mag;
    logic [3:0]      r_ones;
    logic [1:0]      r_tens;

    // Displayed value; only changes in LOAD
    logic            r_disp_sign;
    logic [1:0]      r_disp_tens;
    logic [3:0]      r_disp_ones;
    logic            r_shown;

    logic [c_CW-1:0] r_refresh_cnt;
    logic [1:0]      r_index;
    logic            r_busy;
    logic            r_done;

    logic            w_cap_sign;
    logic [4:0]      w_cap_mag;
    logic [3:0]      w_ones_adj;

    // Two's complement negate wraps in 5 bits, so -16 yields magnitude 16.
    assign w_cap_sign = signed_i & result_i[4];
    assign w_cap_mag  = w_cap_sign ? (~result_i + 5'd1) : result_i;
    assign w_ones_adj = (r_ones >= 4'd5) ? (r_ones + 4'd3) : r_ones;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= c_ST_IDLE;
            r_step        <= 3'd0;
            r_sign        <= 1'b0;
            r_mag         <= 5'd0;
            r_ones        <= 4'd0;
            r_tens        <= 2'd0;
            r_disp_sign   <= 1'b0;
            r_disp_tens   <= 2'd0;
            r_disp_ones   <= 4'd0;
            r_shown       <= 1'b0;
            r_refresh_cnt <= '0;
            r_index       <= 2'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            // Digit multiplexing runs independently of the FSM and of clear_i.
            if (r_refresh_cnt == c_REFRESH_LAST) begin
                r_refresh_cnt <= '0;
                r_index       <= (r_index == 2'd2) ? 2'd0 : r_index + 2'd1;
            end else begin
                r_refresh_cnt <= r_refresh_cnt + c_CNT_ONE;
            end

            r_done <= 1'b0;
            // busy follows the state of the cycle just finished, so it is
            // high on the edges that leave CONVERT and LOAD.
            r_busy <= (r_state == c_ST_CONVERT) || (r_state == c_ST_LOAD);

            if (clear_i) begin
                r_state <= c_ST_IDLE;
                r_shown <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (capture_i && result_valid_i) begin
                            r_sign  <= w_cap_sign;
                            r_mag   <= w_cap_mag;
                            r_ones  <= 4'd0;
                            r_tens  <= 2'd0;
                            r_step  <= 3'd0;
                            r_state <= c_ST_CONVERT;
                        end
                    end
                    c_ST_CONVERT: begin
                        // Add-3 on ones, then shift {tens, ones, mag} left by one.
                        r_tens <= {r_tens[0], w_ones_adj[3]};
                        r_ones <= {w_ones_adj[2:0], r_mag[4]};
                        r_mag  <= {r_mag[3:0], 1'b0};
                        if (r_step == 3'd4) begin
                            r_state <= c_ST_LOAD;
                        end else begin
                            r_step <= r_step + 3'd1;
                        end
                    end
                    c_ST_LOAD: begin
                        r_disp_sign <= r_sign;
                        r_disp_tens <= r_tens;
                        r_disp_ones <= r_ones;
                        r_shown     <= 1'b1;
                        r_done      <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        an_o  = 3'b001 << r_index;
        seg_o = 7'h00;
        if (r_shown) begin
            case (r_index)
                2'd0: seg_o = f_seg(r_disp_ones);
                2'd1: if (r_disp_tens != 2'd0) seg_o = f_seg({2'b00, r_disp_tens});
                2'd2: if (r_disp_sign) seg_o = c_SEG_MINUS;
                default: seg_o = 7'h00;
            endcase
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;

endmodule
`default_nettype wire
